// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the pipeline MEM stage (A) and a debug port (B).
// A has priority. A waiting B is forced through after STARVE_LIMIT consecutive A wins. Each access takes 2 cycles.
module dmem_arbiter #(
  parameter  int NUM_WORDS    = 512,
  parameter  int STARVE_LIMIT = 4,
  localparam int ADDR_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int CNT_W        = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [31:0]       A_ADDR,
  input  logic [31:0]       A_WDATA,
  output logic              A_GNT,
  output logic              A_DONE,
  output logic [31:0]       A_RDATA,
  output logic              A_ERR,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [31:0]       B_ADDR,
  input  logic [31:0]       B_WDATA,
  output logic              B_GNT,
  output logic              B_DONE,
  output logic [31:0]       B_RDATA,
  output logic              B_ERR,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_WDATA,
  input  logic [31:0]       MEM_RDATA,
  output logic              BUSY
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [32:0] BYTE_LIMIT = 33'(NUM_WORDS) << 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  function automatic logic addr_err(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || ({1'b0, addr} >= BYTE_LIMIT);
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              win_b_q, win_b_d;
  logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic              a_done_q, a_done_d, b_done_q, b_done_d;
  logic              a_err_q, a_err_d, b_err_q, b_err_d;
  logic [31:0]       a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              pick_b;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_err;
  logic [31:0]       rd_capture;

  always_comb begin
    pick_b    = B_REQ && (!A_REQ || (starve_cnt_q == CNT_MAX));
    sel_we    = pick_b ? B_WE    : A_WE;
    sel_addr  = pick_b ? B_ADDR  : A_ADDR;
    sel_wdata = pick_b ? B_WDATA : A_WDATA;
    sel_err   = addr_err(sel_addr);
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    we_d         = we_q;
    err_d        = err_q;
    win_b_d      = win_b_q;
    a_gnt_d      = 1'b0;
    b_gnt_d      = 1'b0;
    a_done_d     = 1'b0;
    b_done_d     = 1'b0;
    a_err_d      = 1'b0;
    b_err_d      = 1'b0;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rd_capture   = (we_q || err_q) ? 32'h0 : MEM_RDATA;

    unique case (state_q)
      IDLE, RESP: begin
        if (A_REQ || B_REQ) begin
          state_d     = ACCESS;
          we_d        = sel_we;
          err_d       = sel_err;
          win_b_d     = pick_b;
          a_gnt_d     = !pick_b;
          b_gnt_d     = pick_b;
          mem_en_d    = !sel_err;
          mem_we_d    = sel_we && !sel_err;
          mem_addr_d  = sel_addr[ADDR_W+1:2];
          mem_wdata_d = sel_wdata;
          // B only counts as starved while it is actually waiting.
          if (pick_b) begin
            starve_cnt_d = '0;
          end else if (B_REQ && (starve_cnt_q < CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (win_b_q) begin
          b_done_d  = 1'b1;
          b_err_d   = err_q;
          b_rdata_d = rd_capture;
        end else begin
          a_done_d  = 1'b1;
          a_err_d   = err_q;
          a_rdata_d = rd_capture;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      win_b_q      <= 1'b0;
      a_gnt_q      <= 1'b0;
      b_gnt_q      <= 1'b0;
      a_done_q     <= 1'b0;
      b_done_q     <= 1'b0;
      a_err_q      <= 1'b0;
      b_err_q      <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      we_q         <= we_d;
      err_q        <= err_d;
      win_b_q      <= win_b_d;
      a_gnt_q      <= a_gnt_d;
      b_gnt_q      <= b_gnt_d;
      a_done_q     <= a_done_d;
      b_done_q     <= b_done_d;
      a_err_q      <= a_err_d;
      b_err_q      <= b_err_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign A_GNT     = a_gnt_q;
  assign B_GNT     = b_gnt_q;
  assign A_DONE    = a_done_q;
  assign B_DONE    = b_done_q;
  assign A_ERR     = a_err_q;
  assign B_ERR     = b_err_q;
  assign A_RDATA   = a_rdata_q;
  assign B_RDATA   = b_rdata_q;
  assign MEM_EN    = mem_en_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected responses, a monitor checks every DONE.
module tb_dmem_arbiter;
  localparam int NW = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_en, mem_we, busy;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [NW];

  dmem_arbiter #(.NUM_WORDS(NW), .STARVE_LIMIT(4)) dut (
    .CLOCK(clk), .RESET_N(rst_n),
    .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wdata),
    .A_GNT(a_gnt), .A_DONE(a_done), .A_RDATA(a_rdata), .A_ERR(a_err),
    .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wdata),
    .B_GNT(b_gnt), .B_DONE(b_done), .B_RDATA(b_rdata), .B_ERR(b_err),
    .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata), .BUSY(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  logic glog[$];
  int   gcyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   we_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, want, $time);
    end
  endfunction

  exp_t ea, eb;
  always @(negedge clk) begin
    if (mem_we) we_cycles++;
    if (a_gnt) begin glog.push_back(1'b0); gcyc.push_back(cyc); end
    if (b_gnt) begin glog.push_back(1'b1); gcyc.push_back(cyc); end
    chk("single_grant", {31'b0, a_gnt & b_gnt}, 32'd0);
    if (a_done) begin
      chk("a_done_expected", {31'b0, exp_a.size() != 0}, 32'd1);
      if (exp_a.size() != 0) begin
        ea = exp_a.pop_front();
        chk("a_rdata", a_rdata, ea.rdata);
        chk("a_err", {31'b0, a_err}, {31'b0, ea.err});
      end
    end else begin
      chk("a_err_idle", {31'b0, a_err}, 32'd0);
    end
    if (b_done) begin
      chk("b_done_expected", {31'b0, exp_b.size() != 0}, 32'd1);
      if (exp_b.size() != 0) begin
        eb = exp_b.pop_front();
        chk("b_rdata", b_rdata, eb.rdata);
        chk("b_err", {31'b0, b_err}, {31'b0, eb.err});
      end
    end else begin
      chk("b_err_idle", {31'b0, b_err}, 32'd0);
    end
  end

  // Entered and left on a falling edge; expects the arbiter idle on entry.
  task automatic do_req(input bit port_b, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata_exp, input logic err_exp);
    exp_t e;
    int n;
    logic [31:0] word;
    logic g;
    e.rdata = rdata_exp;
    e.err   = err_exp;
    word    = addr >> 2;
    if (port_b) begin
      exp_b.push_back(e);
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      exp_a.push_back(e);
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      g = port_b ? b_gnt : a_gnt;
    end while (!g && n < 20);
    chk("gnt_seen", {31'b0, g}, 32'd1);
    chk("gnt_latency", n, 32'd1);
    chk("access_mem_en", {31'b0, mem_en}, {31'b0, !err_exp});
    chk("access_mem_we", {31'b0, mem_we}, {31'b0, we & !err_exp});
    chk("access_busy", {31'b0, busy}, 32'd1);
    if (!err_exp) chk("access_mem_addr", {23'b0, mem_addr}, {23'b0, word[8:0]});
    if (we && !err_exp) chk("access_mem_wdata", mem_wdata, wdata);
    if (port_b) begin b_req = 1'b0; b_addr = 32'hFFFF_FFFF; end
    else begin a_req = 1'b0; a_addr = 32'hFFFF_FFFF; end
    @(negedge clk);
    chk("resp_done", {31'b0, port_b ? b_done : a_done}, 32'd1);
    chk("resp_busy", {31'b0, busy}, 32'd1);
    chk("resp_mem_en", {31'b0, mem_en}, 32'd0);
    chk("resp_gnt", {31'b0, port_b ? b_gnt : a_gnt}, 32'd0);
    @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_done", {31'b0, port_b ? b_done : a_done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    automatic bit exp_ord[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int n;
    int w0;
    for (int i = 0; i < NW; i++) mem[i] = 32'h0;
    mem[3]   = 32'hDEAD_BEEF;
    mem[4]   = 32'hCAFE_F00D;
    mem[511] = 32'hA5A5_5A5A;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_a_gnt", {31'b0, a_gnt}, 32'd0);
    chk("rst_b_gnt", {31'b0, b_gnt}, 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    chk("rst_mem_addr", {23'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    // Single read, write then read-back
    do_req(1'b0, 1'b0, 32'h0000_000C, 32'h0, 32'hDEAD_BEEF, 1'b0);
    chk("rdata_hold", a_rdata, 32'hDEAD_BEEF);
    w0 = we_cycles;
    do_req(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'h0, 1'b0);
    chk("we_count_write", we_cycles - w0, 32'd1);
    chk("mem16_written", mem[16], 32'h1234_5678);
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 1'b0);
    chk("we_count_read", we_cycles - w0, 32'd1);

    // Error and boundary addresses
    w0 = we_cycles;
    do_req(1'b0, 1'b1, 32'h0000_0802, 32'h55AA_55AA, 32'h0, 1'b1);
    do_req(1'b0, 1'b0, 32'h0000_0800, 32'h0, 32'h0, 1'b1);
    do_req(1'b0, 1'b0, 32'h0000_000D, 32'h0, 32'h0, 1'b1);
    do_req(1'b0, 1'b0, 32'h0000_07FC, 32'h0, 32'hA5A5_5A5A, 1'b0);
    chk("err_no_write", we_cycles - w0, 32'd0);
    chk("mem0_untouched", mem[0], 32'h0);

    // Starvation with both ports requesting continuously from reset
    rst_n = 1'b0;
    @(negedge clk);
    glog.delete();
    gcyc.delete();
    for (int i = 0; i < 10; i++) begin
      if (exp_ord[i]) exp_b.push_back('{rdata: 32'h1234_5678, err: 1'b0});
      else            exp_a.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
    end
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0000_000C;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h0000_0040;
    rst_n = 1'b1;
    n = 0;
    while (glog.size() < 10 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    a_req = 1'b0;
    b_req = 1'b0;
    chk("starve_grant_count", glog.size(), 32'd10);
    if (glog.size() >= 10) begin
      for (int i = 0; i < 10; i++) chk($sformatf("starve_order_%0d", i), {31'b0, glog[i]}, {31'b0, exp_ord[i]});
      chk("starve_b_spacing", gcyc[9] - gcyc[4], 32'd10);
    end
    repeat (3) @(negedge clk);
    chk("starve_idle", {31'b0, busy}, 32'd0);
    chk("starve_a_drained", exp_a.size(), 32'd0);
    chk("starve_b_drained", exp_b.size(), 32'd0);

    // Reset during the ACCESS cycle of a write
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h0000_0010; a_wdata = 32'h1111_1111;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h0000_0040;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!a_gnt && n < 20);
    chk("rst_mid_gnt", {31'b0, a_gnt}, 32'd1);
    chk("rst_mid_we_before", {31'b0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we_after", {31'b0, mem_we}, 32'd0);
    chk("rst_mid_en_after", {31'b0, mem_en}, 32'd0);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_gnt_after", {31'b0, a_gnt}, 32'd0);
    chk("rst_mid_starve", {29'b0, dut.starve_cnt_q}, 32'd0);
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem4", mem[4], 32'hCAFE_F00D);
    chk("rst_mid_no_done", {31'b0, a_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 1'b0);

    chk("final_a_drained", exp_a.size(), 32'd0);
    chk("final_b_drained", exp_b.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
